// File: rtl/alu_instr_sequencer_pkg.sv
// Shared constants for the instruction sequencer and the ALU result mux:
// widths, opcode values, instruction field positions and FSM state encoding.
package alu_instr_sequencer_pkg;

  localparam int DATA_W  = 4;
  localparam int NREGS   = 4;
  localparam int ADDR_W  = 2;
  localparam int OPC_W   = 3;
  localparam int INSTR_W = 11;

  // Instruction layout: [10:8] opcode, [7:6] rd, [5:4] rs, [3:0] imm
  localparam int OPC_LSB = 8;
  localparam int RD_LSB  = 6;
  localparam int RS_LSB  = 4;
  localparam int IMM_LSB = 0;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD   = 3'd0,
    OP_COMP  = 3'd1,
    OP_SHR   = 3'd2,
    OP_SHL   = 3'd3,
    OP_COMPC = 3'd4,
    OP_COMPN = 3'd5,
    OP_ONE   = 3'd6,
    OP_LOAD  = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  function automatic logic [OPC_W-1:0] instr_opcode(input logic [INSTR_W-1:0] i);
    return i[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [ADDR_W-1:0] instr_rd(input logic [INSTR_W-1:0] i);
    return i[RD_LSB +: ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] instr_rs(input logic [INSTR_W-1:0] i);
    return i[RS_LSB +: ADDR_W];
  endfunction

  function automatic logic [DATA_W-1:0] instr_imm(input logic [INSTR_W-1:0] i);
    return i[IMM_LSB +: DATA_W];
  endfunction

endpackage

// File: rtl/alu_instr_sequencer_regfile.sv
// 4x4-bit register file: one synchronous write port, two combinational read
// ports plus a debug read port, synchronous active-low clear.
module alu_regfile
  import alu_instr_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_instr_sequencer.sv
// Instruction-issue sequencer: accepts an instruction, presents opcode and
// operands to the ALU, writes the ALU result back. Optional: ALU_ZERO_FLAG_EN.
module alu_instr_sequencer
  import alu_instr_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  // Handshake: an instruction transfers on a rising edge where
  // instr_valid && instr_ready; the producer holds instr while valid && !ready.
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [OPC_W-1:0]   opcode,
  output logic [DATA_W-1:0]  operand_a,
  output logic [DATA_W-1:0]  operand_b,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               wb_valid,
  output logic [ADDR_W-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
`ifdef ALU_ZERO_FLAG_EN
  output logic               zero_flag,
`endif
  output state_e             dbg_state,
  input  logic [ADDR_W-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e state, state_d;
  logic   accept, wb_en;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  logic [OPC_W-1:0]  opc_in;
  logic [ADDR_W-1:0] rd_in, rs_in;
  logic [DATA_W-1:0] imm_in;

  assign opc_in    = instr_opcode(instr);
  assign rd_in     = instr_rd(instr);
  assign rs_in     = instr_rs(instr);
  assign imm_in    = instr_imm(instr);
  assign dbg_state = state;

  alu_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_en),
    .waddr    (rd_q),
    .wdata    (alu_result),
    .raddr_a  (rd_in),
    .rdata_a  (rdata_a),
    .raddr_b  (rs_in),
    .rdata_b  (rdata_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    wb_en   = 1'b0;
    case (state)
      IDLE: if (instr_valid && instr_ready) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        wb_en   = 1'b1;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; ready tracks the state we are about to enter so it is
  // high exactly in IDLE and low the cycle reset is active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_ready <= 1'b0;
      opcode      <= '0;
      operand_a   <= '0;
      operand_b   <= '0;
      rd_q        <= '0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
    end else begin
      instr_ready <= (state_d == IDLE);
      wb_valid    <= wb_en;
      if (accept) begin
        opcode    <= opc_in;
        operand_a <= rdata_a;
        operand_b <= (opc_in == OP_LOAD) ? imm_in : rdata_b;
        rd_q      <= rd_in;
      end
      if (wb_en) begin
        wb_addr <= rd_q;
        wb_data <= alu_result;
      end
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (!rst_n)     zero_flag <= 1'b0;
    else if (wb_en) zero_flag <= (alu_result == '0);
  end
`endif

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Bench for alu_instr_sequencer: directed scenarios plus random instructions
// checked against a register-array model and a behavioural ALU.
module tb_alu_instr_sequencer;
  import alu_instr_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  opcode;
  logic [3:0]  operand_a, operand_b, alu_result;
  logic        wb_valid;
  logic [1:0]  wb_addr;
  logic [3:0]  wb_data;
  state_e      dbg_state;
  logic [1:0]  dbg_addr;
  logic [3:0]  dbg_data;
`ifdef ALU_ZERO_FLAG_EN
  logic        zero_flag;
`endif

  alu_instr_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
`ifdef ALU_ZERO_FLAG_EN
    .zero_flag   (zero_flag),
`endif
    .dbg_state   (dbg_state),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Behavioural ALU result mux sitting on the other side of the sequencer
  function automatic logic [3:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return ~a;
      3'd2:    return a >> 1;
      3'd3:    return a << 1;
      3'd4:    return ~b;
      3'd5:    return 4'(-a);
      3'd6:    return 4'h1;
      default: return b;
    endcase
  endfunction

  assign alu_result = alu_f(opcode, operand_a, operand_b);

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  int          wb_cnt = 0;
  int          n_instr = 0;
  int          last_wait = 0;
  logic [3:0]  ref_regs [4];
  logic [2:0]  last_op = '0;
  logic [3:0]  last_a = '0, last_b = '0, last_res = '0;
  logic [1:0]  last_rd = '0;
  logic        last_zero = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (wb_valid === 1'b1) wb_cnt++;

  // driver: issue one instruction and follow it through EXEC and WB
  task automatic run_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                           input logic [3:0] imm, input bit keep_valid, input logic [10:0] nxt);
    int waits;
    logic [3:0] b, res;
    instr       = {op, rd, rs, imm};
    instr_valid = 1'b1;
    dbg_addr    = rd;
    waits = 0;
    while (instr_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    last_wait = waits;
    if (instr_ready !== 1'b1) begin
      check("accept_timeout", 32'(instr_ready), 32'd1);
      instr_valid = 1'b0;
      return;
    end
    b   = (op == 3'd7) ? imm : ref_regs[rs];
    res = alu_f(op, ref_regs[rd], b);
    exp_q.push_back({26'd0, rd, res});

    @(negedge clk);  // EXEC
    if (keep_valid) instr = nxt;
    else            instr_valid = 1'b0;
    check("exec_state",   32'(dbg_state),   32'(EXEC));
    check("exec_opcode",  32'(opcode),      32'(op));
    check("exec_op_a",    32'(operand_a),   32'(ref_regs[rd]));
    check("exec_op_b",    32'(operand_b),   32'(b));
    check("exec_ready",   32'(instr_ready), 32'd0);
    check("exec_wbvalid", 32'(wb_valid),    32'd0);
    check("exec_dbg_old", 32'(dbg_data),    32'(ref_regs[rd]));

    @(negedge clk);  // WB
    ref_regs[rd] = res;
    begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("wb_valid", 32'(wb_valid), 32'd1);
      check("wb_addr",  32'(wb_addr),  32'(e[5:4]));
      check("wb_data",  32'(wb_data),  32'(e[3:0]));
    end
    check("wb_ready",   32'(instr_ready), 32'd0);
    check("wb_dbg_new", 32'(dbg_data),    32'(res));
    last_zero = (res == 4'h0);
`ifdef ALU_ZERO_FLAG_EN
    check("zero_flag", 32'(zero_flag), 32'(last_zero));
`endif

    @(negedge clk);  // back in IDLE
    check("idle_wbvalid", 32'(wb_valid),    32'd0);
    check("idle_ready",   32'(instr_ready), 32'd1);
    last_op = op; last_a = ref_regs[rd]; last_b = b; last_res = res; last_rd = rd;
    last_a = (rd == rs && op != 3'd7) ? last_a : last_a;
    n_instr++;
  endtask

  initial begin
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [3:0] imm;
    logic [10:0] nxt;
    bit keep;
    int wbc;

    for (int i = 0; i < 4; i++) ref_regs[i] = '0;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",   32'(instr_ready), 32'd0);
    check("rst_wbvalid", 32'(wb_valid),    32'd0);
    check("rst_opcode",  32'(opcode),      32'd0);
    check("rst_op_a",    32'(operand_a),   32'd0);
    check("rst_op_b",    32'(operand_b),   32'd0);
    check("rst_wb_addr", 32'(wb_addr),     32'd0);
    check("rst_wb_data", 32'(wb_data),     32'd0);
    check("rst_state",   32'(dbg_state),   32'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(instr_ready), 32'd1);

    // reset in the middle of EXEC aborts the writeback
    run_instr(3'd7, 2'd1, 2'd0, 4'h7, 1'b0, '0);
    instr = {3'd7, 2'd1, 2'd0, 4'hA}; instr_valid = 1'b1; dbg_addr = 2'd1;
    @(negedge clk);
    check("rst_test_exec", 32'(dbg_state), 32'(EXEC));
    instr_valid = 1'b0; rst_n = 1'b0; wbc = wb_cnt;
    @(negedge clk);
    check("midreset_wbvalid", 32'(wb_valid),    32'd0);
    check("midreset_ready",   32'(instr_ready), 32'd0);
    check("midreset_reg1",    32'(dbg_data),    32'd0);
    @(negedge clk);
    check("midreset_no_wb",   32'(wb_cnt),      32'(wbc));
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) ref_regs[i] = '0;
    last_op = '0; last_a = '0; last_b = '0; last_zero = 1'b0;
    @(negedge clk);
    check("midreset_ready_release", 32'(instr_ready), 32'd1);
    n_instr = 1;  // the aborted LOAD never writes back
    wb_cnt  = 1;

    // LOAD then read back
    run_instr(3'd7, 2'd2, 2'd0, 4'h5, 1'b0, '0);

    // ADD dependency chain: r0 = 3 + 4, then 7 + 4
    run_instr(3'd7, 2'd0, 2'd0, 4'h3, 1'b0, '0);
    run_instr(3'd7, 2'd1, 2'd0, 4'h4, 1'b0, '0);
    run_instr(3'd0, 2'd0, 2'd1, 4'h0, 1'b0, '0);
    run_instr(3'd0, 2'd0, 2'd1, 4'h0, 1'b0, '0);
    check("add_chain_r0", 32'(ref_regs[0]), 32'd11);

    // handshake stall: next instruction held valid through EXEC/WB
    run_instr(3'd7, 2'd3, 2'd0, 4'h9, 1'b1, {3'd0, 2'd3, 2'd3, 4'h0});
    run_instr(3'd0, 2'd3, 2'd3, 4'h0, 1'b0, '0);
    check("stall_accept_first_idle", 32'(last_wait), 32'd0);
    check("stall_one_wb_each", 32'(wb_cnt), 32'(n_instr));

    // OP_ONE and a zero result
    run_instr(3'd6, 2'd3, 2'd0, 4'h0, 1'b0, '0);
    run_instr(3'd7, 2'd2, 2'd0, 4'hF, 1'b0, '0);
    run_instr(3'd1, 2'd2, 2'd0, 4'h0, 1'b0, '0);

    // idle hold
    instr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      instr    = 11'($urandom_range(0, 2047));
      dbg_addr = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("hold_ready",   32'(instr_ready), 32'd1);
      check("hold_wbvalid", 32'(wb_valid),    32'd0);
      check("hold_opcode",  32'(opcode),      32'(last_op));
      check("hold_op_b",    32'(operand_b),   32'(last_b));
      check("hold_wb_data", 32'(wb_data),     32'(last_res));
      check("hold_dbg",     32'(dbg_data),    32'(ref_regs[dbg_addr]));
`ifdef ALU_ZERO_FLAG_EN
      check("hold_zero",    32'(zero_flag),   32'(last_zero));
`endif
    end

    // random instructions, sometimes stalled behind the previous one
    op  = 3'($urandom_range(0, 7));
    rd  = 2'($urandom_range(0, 3));
    rs  = 2'($urandom_range(0, 3));
    imm = 4'($urandom_range(0, 15));
    for (int i = 0; i < 40; i++) begin
      nxt  = 11'($urandom_range(0, 2047));
      keep = ($urandom_range(0, 1) == 1);
      run_instr(op, rd, rs, imm, keep, nxt);
      if (keep) begin
        op = nxt[10:8]; rd = nxt[7:6]; rs = nxt[5:4]; imm = nxt[3:0];
      end else begin
        op  = 3'($urandom_range(0, 7));
        rd  = 2'($urandom_range(0, 3));
        rs  = 2'($urandom_range(0, 3));
        imm = 4'($urandom_range(0, 15));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    run_instr(op, rd, rs, imm, 1'b0, '0);

    @(negedge clk);
    check("total_wb_count", 32'(wb_cnt), 32'(n_instr));
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      @(negedge clk);
      check("final_reg", 32'(dbg_data), 32'(ref_regs[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
